// File: rtl/spawn_pkg.sv
// rtl/spawn_pkg.sv - shared types and lane tables for the frame-rate spawn scheduler
package spawn_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, READY, LAUNCH, FLIGHT} sched_state_t;

  localparam int NUM_OBST  = 4;
  localparam int NUM_LANES = 3;

  // Packed so that bit i of obst_active selects element i: [3]=rock_left .. [0]=tree_right
  localparam logic [NUM_OBST-1:0][NUM_LANES-1:0] OBST_LANE_MASK =
    {3'b001, 3'b100, 3'b011, 3'b110};

  function automatic logic [NUM_LANES-1:0] lanes_of(input logic [NUM_OBST-1:0] act);
    logic [NUM_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_OBST; i++) begin
      if (act[i]) m = m | OBST_LANE_MASK[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/spawn_level_ctr.sv
// rtl/spawn_level_ctr.sv - play-time frame counter, saturating difficulty level and spawn threshold
module spawn_level_ctr
  import spawn_pkg::*;
#(
  parameter int LEVEL_FRAMES = 600,
  parameter int MAX_LEVEL    = 7,
  parameter int BASE_THRESH  = 26,
  parameter int LEVEL_STEP   = 13
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clear_i,
  input  logic       en_i,
  output logic [2:0] level_o,
  output logic [7:0] thresh_o
);

  localparam int FW = $clog2(LEVEL_FRAMES);

  logic [FW-1:0] frame_q, frame_d;
  logic [2:0]    level_q, level_d;
  logic [8:0]    thresh_wide;

  always_comb begin
    frame_d = frame_q;
    level_d = level_q;
    if (clear_i) begin
      frame_d = '0;
      level_d = '0;
    end else if (en_i) begin
      if (frame_q == FW'(LEVEL_FRAMES - 1)) begin
        frame_d = '0;
        if (level_q != 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      frame_q <= '0;
      level_q <= '0;
    end else begin
      frame_q <= frame_d;
      level_q <= level_d;
    end
  end

  // Sum is formed 9 bits wide so a large level saturates instead of wrapping
  assign thresh_wide = 9'(BASE_THRESH) + 9'(level_q) * 9'(LEVEL_STEP);
  assign thresh_o    = thresh_wide[8] ? 8'hFF : thresh_wide[7:0];
  assign level_o     = level_q;

endmodule

// File: rtl/spawn_scheduler.sv
// rtl/spawn_scheduler.sv - one-obstacle-at-a-time spawn FSM with round-robin coin grants
// Optional obstacle grant counter output enabled by SPAWN_SCHED_STATS_EN.
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int GAP_FRAMES   = 30,
  parameter int BASE_THRESH  = 26,
  parameter int LEVEL_STEP   = 13,
  parameter int LEVEL_FRAMES = 600,
  parameter int MAX_LEVEL    = 7,
  parameter int LAUNCH_TO    = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        run_i,
  input  logic [19:0] rnd_i,
  input  logic [3:0]  obst_active_i,
  input  logic [2:0]  coin_active_i,
  output logic [3:0]  obst_en_o,
  output logic [2:0]  coin_en_o,
  output logic [2:0]  level_o,
`ifdef SPAWN_SCHED_STATS_EN
  output logic [15:0] obst_count_o,
`endif
  output logic [2:0]  blocked_o
);

  localparam int GW = $clog2(GAP_FRAMES + 1);
  localparam int LW = $clog2(LAUNCH_TO + 1);

  sched_state_t   state_q, state_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [LW-1:0]  launch_q, launch_d;
  logic [1:0]     idx_q, idx_d;
  logic [1:0]     rr_q, rr_d;
  logic [3:0]     obst_en_q, obst_en_d;
  logic [2:0]     coin_en_q, coin_en_d;
  logic [2:0]     blocked_q, blocked_d;
  logic [2:0]     blk_now, cand;
  logic [7:0]     thresh;
  logic           grant, found;
  int             lane;
  logic           unused_rnd_hi;

  assign unused_rnd_hi = ^rnd_i[19:13];

  spawn_level_ctr #(
    .LEVEL_FRAMES (LEVEL_FRAMES),
    .MAX_LEVEL    (MAX_LEVEL),
    .BASE_THRESH  (BASE_THRESH),
    .LEVEL_STEP   (LEVEL_STEP)
  ) u_level_ctr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (!run_i),
    .en_i     (state_q != IDLE),
    .level_o  (level_o),
    .thresh_o (thresh)
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    launch_d  = launch_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    obst_en_d = '0;
    coin_en_d = '0;
    grant     = 1'b0;
    found     = 1'b0;
    lane      = 0;
    cand      = '0;
    blk_now   = lanes_of(obst_active_i) | ((state_q == LAUNCH) ? OBST_LANE_MASK[idx_q] : 3'b000);
    blocked_d = blk_now;

    unique case (state_q)
      IDLE: if (run_i) begin
        state_d = ARMED;
        gap_d   = GW'(GAP_FRAMES);
      end
      ARMED: if (gap_q != '0) gap_d = gap_q - GW'(1);
             else             state_d = READY;
      READY: if (obst_active_i != '0) begin
        state_d = FLIGHT;
      end else if (rnd_i[7:0] < thresh) begin
        grant                   = 1'b1;
        obst_en_d[rnd_i[12:11]] = 1'b1;
        idx_d                   = rnd_i[12:11];
        launch_d                = '0;
        state_d                 = LAUNCH;
      end
      LAUNCH: if (obst_active_i != '0) begin
        state_d = FLIGHT;
      end else if (launch_q == LW'(LAUNCH_TO - 1)) begin
        state_d = ARMED;
        gap_d   = GW'(GAP_FRAMES);
      end else begin
        launch_d = launch_q + LW'(1);
      end
      FLIGHT: if (obst_active_i == '0) begin
        state_d = ARMED;
        gap_d   = GW'(GAP_FRAMES);
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle obstacle grant is not in blk_now yet, so its lanes are masked here too
    if (state_q != IDLE) begin
      cand = rnd_i[10:8] & ~blk_now & ~coin_active_i
           & (grant ? ~OBST_LANE_MASK[rnd_i[12:11]] : 3'b111);
      for (int k = 0; k < NUM_LANES; k++) begin
        lane = (int'(rr_q) + k) % NUM_LANES;
        if (!found && cand[lane]) begin
          found           = 1'b1;
          coin_en_d[lane] = 1'b1;
          rr_d            = 2'((lane + 1) % NUM_LANES);
        end
      end
    end

    if (!run_i) begin
      state_d   = IDLE;
      gap_d     = '0;
      rr_d      = rr_q;
      grant     = 1'b0;
      obst_en_d = '0;
      coin_en_d = '0;
      blocked_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      launch_q  <= '0;
      idx_q     <= '0;
      rr_q      <= '0;
      obst_en_q <= '0;
      coin_en_q <= '0;
      blocked_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      launch_q  <= launch_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      obst_en_q <= obst_en_d;
      coin_en_q <= coin_en_d;
      blocked_q <= blocked_d;
    end
  end

`ifdef SPAWN_SCHED_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || state_q == IDLE) count_q <= '0;
    else if (grant && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
  end

  assign obst_count_o = count_q;
`endif

  assign obst_en_o = obst_en_q;
  assign coin_en_o = coin_en_q;
  assign blocked_o = blocked_q;

endmodule
